// File: rtl/hack_pkg.sv
// Shared Hack CPU types: ROM address width and
// program-counter operation codes.
package hack_pkg;

   localparam int HACK_ADDR_W = 15;

   typedef logic [HACK_ADDR_W-1:0] hack_addr_t;

   typedef enum logic [2:0] {
      PC_HOLD,
      PC_INC,
      PC_LOAD,
      PC_CALL,
      PC_RET,
      PC_CLR
   } pc_op_t;

endpackage

// File: rtl/hack_lifo_regs.sv
// DEPTH x WIDTH flop-based LIFO.
// Ports: clk, rst_n, clr, push, pop, din, dout (top), count, full, empty.
module hack_lifo_regs
   import hack_pkg::*;
#(
   parameter int WIDTH = HACK_ADDR_W,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];

   // Caller guards push-when-full and pop-when-empty;
   // the checks here keep count in range regardless.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (push && !full) begin
         count <= count + CW'(1);
      end else if (pop && !empty) begin
         count <= count - CW'(1);
      end
   end

   // Entry contents need no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (!clr && push && !full && count == CW'(i)) begin
            mem[i] <= din;
         end
      end
   end

   always_comb begin
      dout = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (count == CW'(i + 1)) begin
            dout = mem[i];
         end
      end
   end

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/hack_pc_stack.sv
// Hack PC with prioritised clr/ret/call/load/inc and return stack.
// Ports: clk, rst_n, clr, load, inc, call, ret, load_addr, pc,
// sp_count, stk_full, stk_empty; stk_err with HACK_PC_STACK_ERR_EN.
module hack_pc_stack
   import hack_pkg::*;
#(
   parameter int         WIDTH     = HACK_ADDR_W,
   parameter int         DEPTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic                       load,
   input  logic                       inc,
   input  logic                       call,
   input  logic                       ret,
   input  logic [WIDTH-1:0]           load_addr,
   output logic [WIDTH-1:0]           pc,
   output logic [$clog2(DEPTH+1)-1:0] sp_count,
   output logic                       stk_full,
   output logic                       stk_empty
`ifdef HACK_PC_STACK_ERR_EN
  ,output logic                       stk_err
`endif
);

   pc_op_t           op;
   logic [WIDTH-1:0] pc_nxt;
   logic [WIDTH-1:0] pc_inc;
   logic [WIDTH-1:0] tos;
   logic             push;
   logic             pop;

   assign pc_inc = pc + WIDTH'(1);

   always_comb begin
      op = PC_HOLD;
      if (clr)       op = PC_CLR;
      else if (ret)  op = PC_RET;
      else if (call) op = PC_CALL;
      else if (load) op = PC_LOAD;
      else if (inc)  op = PC_INC;
   end

   assign push = (op == PC_CALL) && !stk_full;
   assign pop  = (op == PC_RET) && !stk_empty;

   always_comb begin
      pc_nxt = pc;
      unique case (op)
         PC_CLR:  pc_nxt = RESET_VEC;
         PC_RET:  pc_nxt = stk_empty ? pc : tos;
         PC_CALL: pc_nxt = load_addr;
         PC_LOAD: pc_nxt = load_addr;
         PC_INC:  pc_nxt = pc_inc;
         default: pc_nxt = pc;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc <= RESET_VEC;
      else        pc <= pc_nxt;
   end

   hack_lifo_regs #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_lifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (op == PC_CLR),
      .push  (push),
      .pop   (pop),
      .din   (pc_inc),
      .dout  (tos),
      .count (sp_count),
      .full  (stk_full),
      .empty (stk_empty)
   );

`ifdef HACK_PC_STACK_ERR_EN
   // Sticky until clr; only executed ops count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stk_err <= 1'b0;
      end else if (op == PC_CLR) begin
         stk_err <= 1'b0;
      end else if ((op == PC_CALL && stk_full) ||
                   (op == PC_RET && stk_empty)) begin
         stk_err <= 1'b1;
      end
   end
`endif

endmodule

// File: doc/hack_pc_stack.md
Name: hack_pc_stack

Overview:
- Parametrised program counter for the Hack CPU, successor to the single-bit flip-flop storage primitives.
- Holds a WIDTH-bit PC with a prioritised clear / load / increment.
- Adds a DEPTH-entry hardware return-address stack for call/return.
- Sits between the instruction decoder/ALU jump logic and the instruction ROM address port.

Parameters:
WIDTH, 15, PC and stack entry width in bits (Hack ROM address width).
DEPTH, 8, number of return-address stack entries; must be >= 2.
RESET_VEC, 0, PC value after async reset or synchronous clear.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
clr  input  1  synchronous clear: PC to RESET_VEC, stack emptied.
load  input  1  jump: PC <= load_addr.
inc  input  1  PC <= PC + 1.
call  input  1  push PC+1, then PC <= load_addr.
ret  input  1  PC <= top of stack, then pop.
load_addr  input  WIDTH  jump/call target.
pc  output  WIDTH  current program counter (registered).
sp_count  output  $clog2(DEPTH+1)  number of valid stack entries.
stk_full  output  1  sp_count == DEPTH.
stk_empty  output  1  sp_count == 0.

Behaviour:
- One clock, with asynchronous active-low reset rst_n. All state updates happen on the rising edge of clk.
- While rst_n is low:
  - pc = RESET_VEC, sp_count = 0, stk_empty = 1, stk_full = 0.
  - Stack entry contents are don't-care.
  - Reset assertion mid-operation aborts any pending push/pop.
- Per-cycle priority, highest first; exactly one action per cycle: clr > ret > call > load > inc > hold.
  - clr: pc <= RESET_VEC; sp_count <= 0.
  - ret, stack non-empty: pc <= stack[sp_count-1]; sp_count <= sp_count-1.
  - ret, stack empty: pc holds, sp_count stays 0 (underflow; no pop).
  - call, stack not full: stack[sp_count] <= pc+1 (mod 2^WIDTH); sp_count <= sp_count+1; pc <= load_addr.
  - call, stack full: pc <= load_addr; push dropped; sp_count stays DEPTH (overflow).
  - load: pc <= load_addr.
  - inc: pc <= pc+1, wrapping from 2^WIDTH-1 to 0 with no flag.
  - none asserted: hold.
- Latency: every output reflects the action one cycle after the edge on which it was sampled. pc is never combinationally driven from the inputs.
- Flags: stk_full and stk_empty are decoded from the registered sp_count, so they are glitch-free and valid in the same cycle as sp_count.
- Arithmetic: pc+1 is computed in WIDTH bits and truncated. The sp_count arithmetic never wraps; the guards above apply.
- Storage: stack entries are plain flops, indexed by sp_count. No read-during-write hazard exists because ret and call are mutually exclusive by priority.

Optional Feature:
Macro HACK_PC_STACK_ERR_EN.
- Defined:
  - Adds output stk_err (1 bit, reset 0).
  - stk_err is set sticky on a call-when-full or ret-when-empty that is actually executed (not masked by a higher-priority input).
  - Cleared only by clr or rst_n.
- Undefined: no stk_err port; overflow and underflow are silent, with the behaviour above.

Decomposition:
- Shared package hack_pkg holds:
  - constant HACK_ADDR_W = 15;
  - typedef hack_addr_t (logic [HACK_ADDR_W-1:0]);
  - enum pc_op_t {PC_HOLD, PC_INC, PC_LOAD, PC_CALL, PC_RET, PC_CLR}, used by the priority decoder and the bench scoreboard.
- Natural sub-module: hack_lifo_regs.
  - Parametrised DEPTH x WIDTH register stack with push/pop, count, full/empty and async active-low reset.
  - Top level holds the PC register and the priority decode.

Test Plan:
- Reset and increment: rst_n low 3 cycles then high; inc=1 for 5 cycles -> pc 0,1,2,3,4,5; stk_empty=1; sp_count=0.
- Priority: pc=10; assert load=1, load_addr=100, inc=1 -> pc=100. Next cycle clr=1 with ret=1 and call=1 -> pc=RESET_VEC, sp_count=0.
- Call/ret nesting: pc=5; call to 0x20, then to 0x40, then to 0x60 -> sp_count=3. Three rets give pc 0x41, 0x21, 6; stk_empty=1 after the last ret.
- Full/overflow: DEPTH=8; 9 consecutive calls starting from pc=0 to addr 0x100+i:
  - stk_full=1 after the 8th call;
  - the 9th call jumps to 0x108 while sp_count stays 8;
  - stk_err=1 with HACK_PC_STACK_ERR_EN.
  - 8 rets then pop in LIFO order.
- Underflow and wrap: stack empty, ret=1 -> pc unchanged, sp_count=0, stk_err=1 with macro. Then load 0x7FFF (WIDTH=15) and inc -> pc=0.
- Async reset mid-call: assert rst_n low between edges while call is pending at sp_count=3 -> pc=RESET_VEC and sp_count=0 immediately, before the next clk edge.
